// File: rtl/periph_rst_seq.sv
// Staged reset sequencer: releases NUM_DOM peripheral resets in index order with a stagger gap and ready handshake.
// Latency: first release STAGGER+2 HCLK edges after SYSRESETn is sampled high; all outputs registered.
// Backpressure: none; software requests queue in a pending mask until the sequence reaches DONE.
//
// Ports:
//   HCLK         system clock, rising edge
//   SYSRESETn    synchronous active-low reset
//   sw_rst_req   per-domain one-cycle software reset request
//   dom_ready    per-domain init-complete level
//   dom_rstn     per-domain active-low reset (registered)
//   seq_done     all domains released, nothing in progress
//   busy         sequencer not in DONE
//   timeout_err  sticky: some domain missed its ack window
//   err_dom      index of the first domain that timed out
module periph_rst_seq #(
  parameter int NUM_DOM     = 4,
  parameter int STAGGER     = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int IDX_W       = 3
) (
  input  logic               HCLK,
  input  logic               SYSRESETn,
  input  logic [NUM_DOM-1:0] sw_rst_req,
  input  logic [NUM_DOM-1:0] dom_ready,
  output logic [NUM_DOM-1:0] dom_rstn,
  output logic               seq_done,
  output logic               busy,
  output logic               timeout_err,
  output logic [IDX_W-1:0]   err_dom
);

  localparam int MAX_CNT = (STAGGER > ACK_TIMEOUT) ? STAGGER : ACK_TIMEOUT;
  localparam int TMR_W   = $clog2(MAX_CNT) + 1;

  localparam logic [TMR_W-1:0] STAG_T = TMR_W'(STAGGER);
  localparam logic [TMR_W-1:0] ACK_T  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    WAIT_ACK,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [NUM_DOM-1:0] pend, pend_nxt;
  logic [NUM_DOM-1:0] rstn_nxt;
  logic               seq_done_nxt;
  logic               busy_nxt;
  logic               err_nxt;
  logic [IDX_W-1:0]   err_dom_nxt;

  // dom_ready of the domain currently being sequenced
  logic               ready_sel;
  // lowest-index domain with a pending software request
  logic [IDX_W-1:0]   low_idx;

  always_comb begin
    ready_sel = 1'b0;
    for (int j = 0; j < NUM_DOM; j++) begin
      if (idx == IDX_W'(j)) ready_sel = dom_ready[j];
    end
  end

  always_comb begin
    low_idx = '0;
    for (int j = NUM_DOM - 1; j >= 0; j--) begin
      if (pend[j]) low_idx = IDX_W'(j);
    end
  end

  always_ff @(posedge HCLK) begin
    if (!SYSRESETn) begin
      state       <= HOLD;
      idx         <= '0;
      timer       <= '0;
      pend        <= '0;
      dom_rstn    <= '0;
      seq_done    <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      err_dom     <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      timer       <= timer_nxt;
      pend        <= pend_nxt;
      dom_rstn    <= rstn_nxt;
      seq_done    <= seq_done_nxt;
      busy        <= busy_nxt;
      timeout_err <= err_nxt;
      err_dom     <= err_dom_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    timer_nxt   = timer;
    pend_nxt    = pend | sw_rst_req;
    rstn_nxt    = dom_rstn;
    err_nxt     = timeout_err;
    err_dom_nxt = err_dom;

    case (state)
      HOLD: begin
        if (timer == STAG_T) begin
          state_nxt = RELEASE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      RELEASE: begin
        for (int j = 0; j < NUM_DOM; j++) begin
          if (idx == IDX_W'(j)) rstn_nxt[j] = 1'b1;
        end
        timer_nxt = '0;
        state_nxt = WAIT_ACK;
      end

      WAIT_ACK: begin
        // A ready seen on the terminal-count cycle wins over the timeout.
        if (ready_sel || (timer == ACK_T)) begin
          if (!ready_sel) begin
            err_nxt = 1'b1;
            if (!timeout_err) err_dom_nxt = idx;
          end
          timer_nxt = '0;
          if (idx == LAST) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = HOLD;
          end
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      DONE: begin
        if (pend != '0) begin
          // Re-sequence the requested domain and every dependent one above it;
          // requests arriving this very cycle stay queued for the next round.
          for (int j = 0; j < NUM_DOM; j++) begin
            if (IDX_W'(j) >= low_idx) rstn_nxt[j] = 1'b0;
          end
          pend_nxt  = sw_rst_req;
          idx_nxt   = low_idx;
          timer_nxt = '0;
          state_nxt = HOLD;
        end
      end

      default: begin
        state_nxt = HOLD;
      end
    endcase

    seq_done_nxt = (state_nxt == DONE);
    busy_nxt     = (state_nxt != DONE);
  end

endmodule

// File: doc/periph_rst_seq.md
Name: periph_rst_seq

Overview:
- Staged reset sequencer for the peripheral reset domains, e.g. video capture, DMA/frame buffer and display.
- Sits downstream of the system reset generator and runs on HCLK.
- Releases NUM_DOM domain resets strictly in index order, with a fixed stagger gap and a per-domain ready handshake.
- Also services per-domain software reset requests, re-sequencing the requested domain and every higher-index (dependent) domain.

Parameters:
- NUM_DOM, 4: number of reset domains; min 2, max 8.
- STAGGER, 16: cycles of hold/gap before each domain release; min 1.
- ACK_TIMEOUT, 1024: max WAIT_ACK cycles before a domain is declared failed; min 2.
- IDX_W, 3: width of domain index; must satisfy 2^IDX_W >= NUM_DOM.

Ports:
- HCLK  in  1  system clock; all logic on its rising edge.
- SYSRESETn  in  1  synchronous active-low reset, sampled on HCLK.
- sw_rst_req  in  NUM_DOM  one-cycle software reset request pulse per domain.
- dom_ready  in  NUM_DOM  level from each domain: init complete after its reset release.
- dom_rstn  out  NUM_DOM  registered active-low reset to each domain.
- seq_done  out  1  high while all domains are released and no sequence is in progress.
- busy  out  1  high while the FSM is not in DONE.
- timeout_err  out  1  sticky: some domain missed the ACK_TIMEOUT.
- err_dom  out  IDX_W  index of the first domain that timed out.

Behaviour:
- Reset:
  - SYSRESETn low at any edge, including mid-sequence, forces the following on the next edge: dom_rstn=0 (all bits), seq_done=0, busy=1, timeout_err=0, err_dom=0, pending mask=0, idx=0, timer=0, state=HOLD.
- States: HOLD, RELEASE, WAIT_ACK, DONE. Only registered outputs.
- HOLD:
  - Timer counts STAGGER cycles, then go to RELEASE with the timer cleared.
  - First HOLD after reset starts at idx=0. dom_rstn[0] is first high STAGGER+2 edges after the first edge sampling SYSRESETn high.
- RELEASE (1 cycle):
  - Set dom_rstn[idx]=1, clear the timer, go to WAIT_ACK.
- WAIT_ACK:
  - dom_ready[idx] is sampled every cycle; the timer increments each cycle.
  - If dom_ready[idx]=1:
    - idx==NUM_DOM-1: go to DONE.
    - Otherwise: idx+1, return to HOLD (the stagger gap).
  - If the timer reaches ACK_TIMEOUT-1 with ready low:
    - Set timeout_err=1.
    - Set err_dom=idx, only if timeout_err was previously 0.
    - Proceed exactly as if acked; the sequence never hangs.
  - dom_ready of other domains is ignored.
  - A ready that arrives in the same cycle as the timeout counts as an ack, with no error.
- DONE:
  - seq_done=1 and busy=0, registered.
  - Both drop on the cycle after a software request is accepted.
- Software reset:
  - sw_rst_req bits are ORed into the pending mask every cycle, in any state.
  - In DONE with pending≠0: k = lowest set bit. On the next edge:
    - dom_rstn[j]=0 for all j>=k.
    - Pending cleared fully; bits set in that same cycle are re-captured.
    - idx=k, state=HOLD.
  - Domains j<k keep dom_rstn=1 throughout.
  - Requests arriving while busy wait in pending and are serviced on the first DONE cycle. seq_done pulses high for exactly 1 cycle in that case.
- dom_rstn bits never glitch. A bit rises only in RELEASE and falls only on SYSRESETn or on software reset acceptance.
- Timer width: clog2(max(STAGGER, ACK_TIMEOUT))+1. No wrap is possible because each state exits before the terminal count.

Test Plan (NUM_DOM=4, STAGGER=4, ACK_TIMEOUT=8):
- Power-up:
  - Stimulus: SYSRESETn low for 3 cycles then high; each dom_ready rises 2 cycles after its dom_rstn.
  - Required: dom_rstn goes 0000→0001→0011→0111→1111, each step spaced by STAGGER+1 plus the ack latency. seq_done=1 one cycle after dom_ready[3]. timeout_err=0.
- Timeout:
  - Stimulus: dom_ready[1] held low.
  - Required: after 8 WAIT_ACK cycles, timeout_err=1, err_dom=1, sequence continues to 1111 with seq_done=1.
  - Stimulus continued: then hold dom_ready[2] low.
  - Required: err_dom stays 1.
- Software reset:
  - Stimulus: in DONE, pulse sw_rst_req=0100.
  - Required: next edge dom_rstn=0011, seq_done=0, busy=1. Re-sequence releases domain 2 then 3, returning to 1111 and seq_done=1.
- Multiple and queued requests:
  - Stimulus: in DONE, pulse sw_rst_req=1010.
  - Required: dom_rstn=0001, re-sequence from domain 1, pending cleared.
  - Stimulus continued: pulse sw_rst_req=0001 during WAIT_ACK of domain 3.
  - Required: seq_done high for 1 cycle, then dom_rstn=0000 and a full resequence.
- Reset mid-operation:
  - Stimulus: drop SYSRESETn for 1 cycle during WAIT_ACK of domain 2 while timeout_err=1.
  - Required: next edge all outputs at reset values (dom_rstn=0000, timeout_err=0). Sequence restarts from domain 0.
- Ack/timeout collision:
  - Stimulus: dom_ready[0] rises exactly on the 8th WAIT_ACK cycle.
  - Required: treated as an ack, timeout_err stays 0.
